// File: rtl/ccsds_psk_modulator.sv
// BPSK/QPSK baseband mapper: accepts coded bits over valid/ready and holds signed I/Q per symbol.
// Optional differential encoding is enabled by defining DIFF_ENC_EN.
module ccsds_psk_modulator #(
  parameter int unsigned DATA_W    = 13,
  parameter int unsigned AMPLITUDE = 4095,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  cycles_per_sym_i,
  input  logic [1:0]        bits_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] i_data_o,
  output logic [DATA_W-1:0] q_data_o,
  output logic              valid_o,
  output logic              underrun_o
);

  localparam logic StIdle = 1'b0;
  localparam logic StSym  = 1'b1;

  localparam logic [DATA_W-1:0] AmpPos = DATA_W'(AMPLITUDE);
  localparam logic [DATA_W-1:0] AmpNeg = ~AmpPos + DATA_W'(1);

  logic              state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              valid_q, valid_d;
  logic              underrun_q, underrun_d;
  logic              sym_last;
  logic              accept;
  logic [1:0]        sym_bits;

  function automatic logic [DATA_W-1:0] map_bit(input logic b);
    return b ? AmpPos : AmpNeg;
  endfunction

  assign sym_last = (state_q == StSym) && (cnt_q == per_q - CNT_W'(1));
  assign ready_o  = (state_q == StIdle) || sym_last;
  assign accept   = valid_i && ready_o;

`ifdef DIFF_ENC_EN
  logic [1:0] diff_q;
  logic [1:0] diff_prev;
  logic [1:0] diff_next;
  logic [1:0] phase_idx;

  // Diff state restarts from zero whenever the accepted symbol switches modulation.
  always_comb begin
    diff_prev = (mode_i != mode_q) ? 2'b00 : diff_q;
    phase_idx = {bits_i[1], bits_i[1] ^ bits_i[0]};
    if (mode_i) begin
      diff_next = diff_prev + phase_idx;
      sym_bits  = {diff_next[1], diff_next[1] ^ diff_next[0]};
    end else begin
      diff_next = {1'b0, bits_i[0] ^ diff_prev[0]};
      sym_bits  = diff_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      diff_q <= 2'b00;
    end else if (accept) begin
      diff_q <= diff_next;
    end
  end
`else
  assign sym_bits = bits_i;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    mode_d     = mode_q;
    i_d        = i_q;
    q_d        = q_q;
    valid_d    = valid_q;
    underrun_d = 1'b0;
    if (accept) begin
      state_d = StSym;
      cnt_d   = '0;
      per_d   = (cycles_per_sym_i == '0) ? CNT_W'(1) : cycles_per_sym_i;
      mode_d  = mode_i;
      valid_d = 1'b1;
      if (mode_i) begin
        i_d = map_bit(sym_bits[1]);
        q_d = map_bit(sym_bits[0]);
      end else begin
        i_d = map_bit(sym_bits[0]);
        q_d = '0;
      end
    end else if (sym_last) begin
      state_d    = StIdle;
      cnt_d      = '0;
      i_d        = '0;
      q_d        = '0;
      valid_d    = 1'b0;
      underrun_d = 1'b1;
    end else if (state_q == StSym) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      per_q      <= CNT_W'(1);
      mode_q     <= 1'b0;
      i_q        <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      mode_q     <= mode_d;
      i_q        <= i_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign i_data_o   = i_q;
  assign q_data_o   = q_q;
  assign valid_o    = valid_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_ccsds_psk_modulator.sv
// Self-checking bench for ccsds_psk_modulator: symbol-level model plus directed literal checks.
// Model and literals follow DIFF_ENC_EN when it is defined.
module tb_ccsds_psk_modulator;

  localparam int DW = 13;
  localparam int A  = 4095;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [CW-1:0] cps;
  logic [1:0]    bits;
  logic          valid;
  logic          ready;
  logic [DW-1:0] idata;
  logic [DW-1:0] qdata;
  logic          vout;
  logic          under;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  always #5 clk = ~clk;

  ccsds_psk_modulator #(
    .DATA_W   (DW),
    .AMPLITUDE(A),
    .CNT_W    (CW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .mode_i          (mode),
    .cycles_per_sym_i(cps),
    .bits_i          (bits),
    .valid_i         (valid),
    .ready_o         (ready),
    .i_data_o        (idata),
    .q_data_o        (qdata),
    .valid_o         (vout),
    .underrun_o      (under)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int amp(input int b);
    return (b != 0) ? A : -A;
  endfunction

  // Symbol-level model: m_left = cycles remaining in the current symbol (0 when idle).
  int m_left = 0;
  int m_i = 0;
  int m_q = 0;
  bit m_v = 0;
  bit m_u = 0;
  bit m_mode = 0;
  bit m_e = 0;
  int m_p = 0;
  int gray2idx[4] = '{0, 1, 3, 2};
  int idx2gray[4] = '{0, 1, 3, 2};

  always @(posedge clk) begin
    bit acc;
    int b1;
    int b0;
    int g;
    acc = valid && (m_left <= 1);
    if (rst) begin
      m_left = 0; m_i = 0; m_q = 0; m_v = 0; m_u = 0;
      m_mode = 0; m_e = 0; m_p = 0;
    end else begin
      m_u = 0;
      if (acc) begin
        m_left = (cps == 0) ? 1 : int'(cps);
        g = 0;
`ifdef DIFF_ENC_EN
        if (mode != m_mode) begin
          m_e = 0;
          m_p = 0;
        end
        if (!mode) begin
          m_e = m_e ^ bits[0];
          b1 = 0;
          b0 = int'(m_e);
        end else begin
          m_p = (m_p + gray2idx[bits]) % 4;
          g = idx2gray[m_p];
          b1 = g / 2;
          b0 = g % 2;
        end
`else
        b1 = int'(bits[1]);
        b0 = int'(bits[0]);
`endif
        m_mode = mode;
        if (mode) begin
          m_i = amp(b1);
          m_q = amp(b0);
        end else begin
          m_i = amp(b0);
          m_q = 0;
        end
        m_v = 1;
      end else if (m_left == 1) begin
        m_left = 0; m_i = 0; m_q = 0; m_v = 0; m_u = 1;
      end else if (m_left > 1) begin
        m_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("ready_o", int'(ready), int'(m_left <= 1));
      chk("valid_o", int'(vout), int'(m_v));
      chk("underrun_o", int'(under), int'(m_u));
      chk("i_data_o", $signed(idata), m_i);
      chk("q_data_o", $signed(qdata), m_q);
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input bit md, input int per, input logic [1:0] b);
    int n;
    n = 0;
    mode  = md;
    cps   = per;
    bits  = b;
    valid = 1'b1;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_timeout", int'(n < 200), 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

`ifdef DIFF_ENC_EN
  int t2_last = -A;
  int t3_i[4] = '{-A, -A, A, A};
  int t3_q[4] = '{-A, A, -A, A};
  int t6_i[4] = '{A, -A, -A, A};
`else
  int t2_last = A;
  int t3_i[4] = '{-A, -A, A, A};
  int t3_q[4] = '{-A, A, A, -A};
  int t6_i[4] = '{A, A, -A, A};
`endif
  logic [1:0] t3_bits[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] t6_bits[4] = '{2'b01, 2'b01, 2'b00, 2'b01};

  initial begin
    rst = 1'b1; mode = 1'b0; cps = 1; bits = 2'b00; valid = 1'b0;
    @(negedge clk);
    check_en = 1;
    repeat (2) @(negedge clk);
    chk("reset_i", $signed(idata), 0);
    chk("reset_valid", int'(vout), 0);
    chk("reset_underrun", int'(under), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(ready), 1);

    // BPSK, per=4, back-to-back
    send(1'b0, 4, 2'b01);
    send(1'b0, 4, 2'b00);
    send(1'b0, 4, 2'b01);
    chk("bpsk_third_i", $signed(idata), t2_last);
    chk("bpsk_q_zero", $signed(qdata), 0);
    repeat (4) @(negedge clk);
    chk("bpsk_underrun", int'(under), 1);
    chk("bpsk_idle_i", $signed(idata), 0);
    repeat (2) @(negedge clk);

    // QPSK, per=2, Gray sweep
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 2, t3_bits[k]);
      chk("qpsk_i", $signed(idata), t3_i[k]);
      chk("qpsk_q", $signed(qdata), t3_q[k]);
    end
    repeat (4) @(negedge clk);

    // per=3 single symbol, underrun, re-accept from idle
    send(1'b0, 3, 2'b01);
    repeat (5) @(negedge clk);
    send(1'b0, 3, 2'b00);
    chk("reaccept_latency", int'(vout), 1);
    repeat (5) @(negedge clk);

    // per=0 treated as 1, continuous
    for (int k = 0; k < 6; k++) send(1'b0, 0, 2'(k % 2));
    chk("per1_ready", int'(ready), 1);
    repeat (3) @(negedge clk);

    // per changed mid-symbol is ignored
    send(1'b0, 3, 2'b01);
    cps = 1;
    repeat (5) @(negedge clk);

    // Differential sequence from a clean state, then reset mid-symbol
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 4, t6_bits[k]);
      chk("bpsk_seq_i", $signed(idata), t6_i[k]);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midsym_reset_valid", int'(vout), 0);
    chk("midsym_reset_i", $signed(idata), 0);
    rst = 1'b0;
    send(1'b0, 4, 2'b01);
    chk("post_reset_i", $signed(idata), A);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
